// File: rtl/lcd_text_arbiter.sv
// lcd_text_arbiter: shares a 2x16 text LCD character buffer between NREQ
// requesters. Write bursts are granted round-robin. The buffer is presented
// as a packed 256-bit frame with char 0 in the MSB byte. A one-cycle
// frame_upd pulse marks each committed burst.
//
// Optional build macro LCD_ARB_SHADOW_EN: writes land in a shadow buffer,
// and the displayed frame is loaded from it only when a burst commits.
// Without the macro, writes go straight to the displayed buffer.
//
// Handshake: req[i] is both "request" and "write valid" for requester i.
// gnt[i] acts as the ready for that requester. A write transfers on every
// rising edge where wr_ack[i] = gnt[i] & req[i] is high. Dropping req while
// granted ends the burst without a transfer.
module lcd_text_arbiter #(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                LCDCLK,
  input  logic                PRESET,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*5-1:0]   wr_addr,
  input  logic [NREQ*8-1:0]   wr_char,
  input  logic [NREQ-1:0]     wr_last,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     wr_ack,
  output logic [255:0]        frame,
  output logic                frame_upd,
  output logic                busy,
  output logic [1:0]          dbg_state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  // last_q is the most recent winner; during OWN it is also the owner.
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          upd_q;

  logic [7:0]    char_q [32];
`ifdef LCD_ARB_SHADOW_EN
  logic [7:0]    shadow_q [32];
`endif

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand_idx;

  logic          own_req;
  logic          own_last;
  logic [4:0]    own_addr;
  logic [7:0]    own_char;
  logic          wr_en;

  // Owner's lane of the request/write buses.
  always_comb begin
    own_req  = req[last_q];
    own_last = wr_last[last_q];
    own_addr = wr_addr[last_q*5 +: 5];
    own_char = wr_char[last_q*8 +: 8];
  end

  // Round-robin search starting at last+1, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IW'((int'(last_q) + k) % NREQ);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: grant, burst accounting and burst termination.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_OWN;
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (own_req) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (own_last || (cnt_d == CW'(MAX_BURST))) begin
            state_d = ST_COMMIT;
          end
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, arbitration pointer, burst counter and commit pulse registers.
  always_ff @(posedge LCDCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      upd_q   <= (state_q == ST_COMMIT);
    end
  end

`ifdef LCD_ARB_SHADOW_EN
  // Burst writes collect in the shadow buffer.
  always_ff @(posedge LCDCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int k = 0; k < 32; k++) shadow_q[k] <= 8'h20;
    end else if (wr_en) begin
      shadow_q[own_addr] <= own_char;
    end
  end

  // Displayed buffer copies the whole shadow on the edge leaving COMMIT.
  always_ff @(posedge LCDCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int k = 0; k < 32; k++) char_q[k] <= 8'h20;
    end else if (state_q == ST_COMMIT) begin
      for (int k = 0; k < 32; k++) char_q[k] <= shadow_q[k];
    end
  end
`else
  // Writes go straight into the displayed buffer.
  always_ff @(posedge LCDCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int k = 0; k < 32; k++) char_q[k] <= 8'h20;
    end else if (wr_en) begin
      char_q[own_addr] <= own_char;
    end
  end
`endif

  // Pack the buffer so that char 0 sits in the MSB byte.
  always_comb begin
    frame = '0;
    for (int k = 0; k < 32; k++) begin
      frame[255-8*k -: 8] = char_q[k];
    end
  end

  // Grant is decoded from state so a reset drops it asynchronously.
  always_comb begin
    gnt         = (state_q == ST_OWN) ? (NREQ'(1) << last_q) : '0;
    wr_ack      = gnt & req;
    busy        = (state_q != ST_IDLE);
    frame_upd   = upd_q;
    dbg_state_o = state_q;
  end

endmodule
